// File: rtl/adc_pkg.sv
// Shared definitions for the serial ADC front end: FSM encoding and default
// AD7477-style frame geometry (4 leading zeros, 10 data bits, 2 trailing).
package adc_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_QUIET = 2'd3;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_LEAD_BITS  = 4;
  localparam int ADC_DATA_BITS  = 10;

endpackage

// File: rtl/adc_serial_sampler_if.sv
// Bundle of the sampler's control, ADC pin and sample-output signals.
// The sampler uses the master view; the ADC and sample consumer use slave.
interface adc_serial_sampler_if #(
  parameter int DATA_BITS = 10
) ();

  logic                 start;
  logic                 continuous;
  logic                 sdata;
  logic                 cs_n;
  logic                 sclk;
  logic [DATA_BITS-1:0] sample;
  logic                 sample_valid;
  logic                 lead_err;
  logic                 busy;

  modport master (
    input  start,
    input  continuous,
    input  sdata,
    output cs_n,
    output sclk,
    output sample,
    output sample_valid,
    output lead_err,
    output busy
  );

  modport slave (
    output start,
    output continuous,
    output sdata,
    input  cs_n,
    input  sclk,
    input  sample,
    input  sample_valid,
    input  lead_err,
    input  busy
  );

endinterface

// File: rtl/clk_en_div.sv
// Clock-enable divider: tick pulses for one clk cycle every CLK_DIV enabled
// cycles; clr restarts the count so every FSM state begins a fresh half-period.
module clk_en_div #(
  parameter int CLK_DIV = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              CW   = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  assign tick = en && (div_cnt_q == LAST);

  // NOTE: every variable gets a default at the top of always_comb, so no
  // branch can leave it unassigned and infer a latch.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr || tick) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values,
  // independent of the order the always blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/adc_serial_sampler.sv
// Serial ADC front end: drives cs_n/sclk from clk via clock enables, shifts in
// one frame MSB first and presents the data field with a one-cycle strobe.
module adc_serial_sampler
  import adc_pkg::*;
#(
  parameter int CLK_DIV      = 7,
  parameter int FRAME_BITS   = ADC_FRAME_BITS,
  parameter int LEAD_BITS    = ADC_LEAD_BITS,
  parameter int DATA_BITS    = ADC_DATA_BITS,
  parameter int QUIET_CYCLES = 50
) (
  input logic                  clk,
  input logic                  rst,
  adc_serial_sampler_if.master bus
);

  localparam int              BW        = $clog2(FRAME_BITS + 1);
  localparam int              QW        = $clog2(QUIET_CYCLES + 1);
  localparam logic [BW-1:0]   BITS_LAST = BW'(FRAME_BITS);
  localparam logic [QW-1:0]   QUIET_END = QW'(QUIET_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [QW-1:0]         quiet_cnt_q, quiet_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0]  sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  lead_err_q, lead_err_d;

  logic tick;
  logic div_en;
  logic div_clr;

  assign div_en  = (state_q == S_SETUP) || (state_q == S_SHIFT);
  assign div_clr = (state_d != state_q);

  clk_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .clr  (div_clr),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    sclk_d      = sclk_q;
    bit_cnt_d   = bit_cnt_q;
    quiet_cnt_d = quiet_cnt_q;
    shift_d     = shift_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    lead_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        sclk_d = 1'b1;
        if (bus.start || bus.continuous) begin
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (tick) begin
          state_d   = S_SHIFT;
          sclk_d    = 1'b0;
          bit_cnt_d = '0;
        end
      end

      S_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d    = 1'b1;
            shift_d   = FRAME_BITS'({shift_q, bus.sdata});
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (bit_cnt_q == BITS_LAST) begin
            // The last sclk high half-period completes before cs_n rises, so
            // the frame spans FRAME_BITS full sclk periods; sclk stays high.
            state_d     = S_QUIET;
            quiet_cnt_d = '0;
            sample_d    = shift_q[FRAME_BITS-1-LEAD_BITS -: DATA_BITS];
            valid_d     = 1'b1;
            lead_err_d  = |shift_q[FRAME_BITS-1 -: LEAD_BITS];
          end else begin
            sclk_d = 1'b0;
          end
        end
      end

      S_QUIET: begin
        sclk_d = 1'b1;
        if (quiet_cnt_q == QUIET_END) begin
          quiet_cnt_d = '0;
          state_d     = bus.continuous ? S_SETUP : S_IDLE;
        end else begin
          quiet_cnt_d = quiet_cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    cs_n_d = !((state_d == S_SETUP) || (state_d == S_SHIFT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      bit_cnt_q   <= '0;
      quiet_cnt_q <= '0;
      shift_q     <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      lead_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      bit_cnt_q   <= bit_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      shift_q     <= shift_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      lead_err_q  <= lead_err_d;
    end
  end

  assign bus.cs_n         = cs_n_q;
  assign bus.sclk         = sclk_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.lead_err     = lead_err_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule
